// File: rtl/reg_bus_initiator_pkg.sv
// Shared types for the REG_BUS initiator: FSM state encoding and the default command record.
package reg_bus_initiator_pkg;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  // Default-width command; the top builds a width-matched copy from its own parameters.
  typedef struct packed {
    logic                            write;
    logic [DefaultAddrWidth-1:0]     addr;
    logic [DefaultDataWidth-1:0]     wdata;
    logic [DefaultDataWidth/8-1:0]   wstrb;
  } cmd_t;

endpackage

// File: rtl/reg_bus.sv
// REG_BUS interface: initiator drives addr/write/wdata/wstrb/valid, target returns rdata/error/ready.
interface REG_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    error;
  logic                    valid;
  logic                    ready;

  modport out (
    output addr, write, wdata, wstrb, valid,
    input  rdata, error, ready
  );

  modport in (
    input  addr, write, wdata, wstrb, valid,
    output rdata, error, ready
  );

endinterface

// File: rtl/reg_bus_initiator_fifo.sv
// Synchronous command FIFO; rst_i flushes it. Pushes when full and pops when empty are ignored.
module reg_bus_initiator_fifo
  import reg_bus_initiator_pkg::*;
#(
  parameter type         entry_t    = cmd_t,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrWidth  = $clog2(FIFO_DEPTH),
  localparam int unsigned CntWidth  = PtrWidth + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push,
  input  entry_t              push_data,
  input  logic                pop,
  output entry_t              pop_data,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  entry_t              mem_q [FIFO_DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q, count_d;
  logic                push_en, pop_en;

  assign full     = (count_q == CntWidth'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + 1'b1;
    end else if (!push_en && pop_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/reg_bus_initiator.sv
// Queued-command REG_BUS initiator, one outstanding transaction at a time.
// Optional REQ-state timeout is built when REG_BUS_INITIATOR_TIMEOUT_EN is defined.
module reg_bus_initiator
  import reg_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o,
  REG_BUS.out                     external_bus_io
);

  localparam int unsigned CntWidth = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } cmd_bus_t;

  state_e                state_q, state_d;
  cmd_bus_t              cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  cmd_bus_t              fifo_push_data, fifo_head;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [CntWidth-1:0]   fifo_count;
  logic                  timed_out;

  assign fifo_push_data = '{write: cmd_write_i, addr: cmd_addr_i,
                            wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};

  reg_bus_initiator_fifo #(
    .entry_t   (cmd_bus_t),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (cmd_valid_i & cmd_ready_o),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign cmd_ready_o = ~fifo_full;
  assign busy_o      = (fifo_count != '0) || (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A ready in the expiry cycle takes precedence over the timeout.
        if (external_bus_io.ready) begin
          error_d = external_bus_io.error;
          rdata_d = cmd_q.write ? '0 : external_bus_io.rdata;
          state_d = RSP;
        end else if (timed_out) begin
          error_d = 1'b1;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);

  logic [TimerWidth-1:0] timer_q;
  logic                  timeout_q;
  logic                  req_waiting;

  assign req_waiting = (state_q == REQ) && !external_bus_io.ready;
  assign timed_out   = req_waiting && (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1));

  // Timer idles at zero outside REQ, so every REQ entry starts from a cleared count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q <= req_waiting ? timer_q + 1'b1 : '0;
      if (state_q == REQ && (external_bus_io.ready || timed_out)) begin
        timeout_q <= ~external_bus_io.ready;
      end
    end
  end

  assign rsp_timeout_o = (state_q == RSP) & timeout_q;
`else
  assign timed_out     = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_error_o = rsp_valid_o & error_q;

  always_comb begin
    external_bus_io.valid = 1'b0;
    external_bus_io.write = 1'b0;
    external_bus_io.addr  = '0;
    external_bus_io.wdata = '0;
    external_bus_io.wstrb = '0;
    if (state_q == REQ) begin
      external_bus_io.valid = 1'b1;
      external_bus_io.write = cmd_q.write;
      external_bus_io.addr  = cmd_q.addr;
      external_bus_io.wdata = cmd_q.wdata;
      external_bus_io.wstrb = cmd_q.wstrb;
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator; timeout cases run when REG_BUS_INITIATOR_TIMEOUT_EN is set.
module tb_reg_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_ready_o, rsp_valid_o, rsp_error_o, rsp_timeout_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] rd_base;
  logic        slv_ready, slv_error;
  int          n_cmp = 0;
  int          n_err = 0;
  int          accepted, n_rsp, vcnt, stray;
  logic [31:0] got [8];

  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  // Target model: read data depends on address so ordering is visible.
  assign bus.rdata = rd_base ^ bus.addr;
  assign bus.ready = slv_ready;
  assign bus.error = slv_error;

  reg_bus_initiator #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_write_i    (cmd_write),
    .cmd_addr_i     (cmd_addr),
    .cmd_wdata_i    (cmd_wdata),
    .cmd_wstrb_i    (cmd_wstrb),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_error_o    (rsp_error_o),
    .rsp_timeout_o  (rsp_timeout_o),
    .busy_o         (busy_o),
    .external_bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid_o) break;
      tick();
    end
    check(tag, rsp_valid_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1; rd_base = 32'hDEAD_BEEF; slv_ready = 1'b0; slv_error = 1'b0;
    tick();
    tick();
    check("reset_cmd_ready", cmd_ready_o, 1'b1);
    check("reset_rsp_valid", rsp_valid_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_bus_valid", bus.valid, 1'b0);
    rst = 1'b0;
    tick();

    // Single write, zero-wait target.
    slv_ready = 1'b1;
    push_cmd(1'b1, 32'h8, 32'h0000_00A5, 4'hF);
    check("wr_c1_valid", bus.valid, 1'b0);
    check("wr_c1_busy", busy_o, 1'b1);
    tick();
    check("wr_c2_valid", bus.valid, 1'b1);
    check("wr_c2_write", bus.write, 1'b1);
    check("wr_c2_addr", bus.addr, 32'h8);
    check("wr_c2_wdata", bus.wdata, 32'hA5);
    check("wr_c2_wstrb", bus.wstrb, 4'hF);
    tick();
    check("wr_c3_rsp_valid", rsp_valid_o, 1'b1);
    check("wr_c3_error", rsp_error_o, 1'b0);
    check("wr_c3_rdata", rsp_rdata_o, 32'h0);
    check("wr_c3_bus_valid", bus.valid, 1'b0);
    tick();
    check("wr_c4_rsp_valid", rsp_valid_o, 1'b0);
    check("wr_c4_busy", busy_o, 1'b0);

    // Read with three wait states.
    slv_ready = 1'b0;
    rd_base = 32'h1234_5638;
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rd_wait_valid", bus.valid, 1'b1);
      check("rd_wait_addr", bus.addr, 32'h40);
      check("rd_wait_rsp", rsp_valid_o, 1'b0);
      if (i == 3) slv_ready = 1'b1;
      tick();
    end
    slv_ready = 1'b0;
    check("rd_rsp_valid", rsp_valid_o, 1'b1);
    check("rd_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
    check("rd_rsp_error", rsp_error_o, 1'b0);
    tick();

    // Fill the queue while responses are backpressured.
    rsp_ready = 1'b0;
    slv_ready = 1'b1;
    rd_base = 32'hC0DE_0000;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h100 + 32'(4 * i);
      if (cmd_ready_o) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 64'(accepted), 64'd5);
    check("fill_cmd_ready", cmd_ready_o, 1'b0);
    check("fill_rsp_valid", rsp_valid_o, 1'b1);
    check("fill_first_rdata", rsp_rdata_o, 32'hC0DE_0100);
    tick();
    check("fill_still_stalled", rsp_valid_o, 1'b1);
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid_o && n_rsp < 8) begin
        got[n_rsp] = rsp_rdata_o;
        n_rsp++;
      end
      tick();
    end
    check("drain_count", 64'(n_rsp), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check("drain_order", got[k], 32'hC0DE_0000 ^ (32'h100 + 32'(4 * k)));
    end
    check("drain_busy", busy_o, 1'b0);
    check("drain_cmd_ready", cmd_ready_o, 1'b1);

    // Target error on a write.
    slv_error = 1'b1;
    rsp_ready = 1'b0;
    push_cmd(1'b1, 32'h20, 32'h5555_AAAA, 4'h3);
    wait_rsp("err_wait_rsp");
    check("err_error", rsp_error_o, 1'b1);
    check("err_timeout", rsp_timeout_o, 1'b0);
    check("err_rdata", rsp_rdata_o, 32'h0);
    slv_error = 1'b0;
    rsp_ready = 1'b1;
    tick();

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    // Target never ready: valid lasts exactly TIMEOUT_CYCLES.
    slv_ready = 1'b0;
    rd_base = 32'h1234_5638;
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.valid) break;
      vcnt++;
      tick();
    end
    check("to_valid_cycles", 64'(vcnt), 64'd8);
    check("to_rsp_valid", rsp_valid_o, 1'b1);
    check("to_error", rsp_error_o, 1'b1);
    check("to_timeout", rsp_timeout_o, 1'b1);
    check("to_rdata", rsp_rdata_o, 32'h0);
    tick();

    // Ready on the final allowed cycle completes normally.
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_late_valid", bus.valid, 1'b1);
      if (i == 7) slv_ready = 1'b1;
      tick();
    end
    slv_ready = 1'b0;
    check("to_late_rsp_valid", rsp_valid_o, 1'b1);
    check("to_late_timeout", rsp_timeout_o, 1'b0);
    check("to_late_error", rsp_error_o, 1'b0);
    check("to_late_rdata", rsp_rdata_o, 32'h1234_5678);
    tick();
`endif

    // Reset pulse mid-transaction with two commands queued.
    slv_ready = 1'b0;
    rsp_ready = 1'b1;
    push_cmd(1'b1, 32'h60, 32'h1, 4'hF);
    push_cmd(1'b1, 32'h64, 32'h2, 4'hF);
    push_cmd(1'b1, 32'h68, 32'h3, 4'hF);
    check("rst_pre_valid", bus.valid, 1'b1);
    check("rst_pre_busy", busy_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_bus_valid", bus.valid, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid_o || bus.valid || busy_o) stray++;
    end
    check("rst_no_activity", 64'(stray), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
